// File: rtl/fcpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fcpu_pkg
//  Brief    : Shared widths and the reorder-buffer entry record for the fcpu
//             integer and float pipelines.
//  Revision : 2.0 - adds rob_entry_t for the multi-port reorder buffer
// ============================================================================
package fcpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int INSTR_W    = 8;

    // One reorder-buffer slot; content is only meaningful once ready is set
    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic                  exc;
        logic [REG_ADDR_W-1:0] dst_reg;
        logic [INSTR_W-1:0]    opcode;
        logic [DATA_W-1:0]     content;
    } rob_entry_t;

endpackage : fcpu_pkg
`default_nettype wire

// File: rtl/rob_age_mask.sv
`default_nettype none
// ============================================================================
//  Module   : rob_age_mask
//  Brief    : Marks every occupied slot that is strictly younger than a given
//             reference id in a circular queue (head = oldest, tail = next
//             free). Shared with the load/store queue.
//  Revision : 1.0 - initial release
// ============================================================================
module rob_age_mask #(
    parameter int DEPTH_W = 3
) (
    input  logic [DEPTH_W-1:0]    head,
    input  logic [DEPTH_W-1:0]    tail,
    input  logic [DEPTH_W-1:0]    flush_id,
    output logic [2**DEPTH_W-1:0] younger
);

    localparam int N = 2**DEPTH_W;

    logic [DEPTH_W-1:0] flush_age;
    logic [DEPTH_W:0]   tail_age;

    // Ages are distances from head. A valid reference id implies a non-empty
    // queue, so head == tail can only mean full here.
    assign flush_age = flush_id - head;
    assign tail_age  = (tail == head) ? (DEPTH_W+1)'(N) : {1'b0, tail - head};

    generate
        for (genvar k = 0; k < N; k++) begin : g_age
            logic [DEPTH_W-1:0] age;
            assign age        = DEPTH_W'(k) - head;
            assign younger[k] = (age > flush_age) && ({1'b0, age} < tail_age);
        end
    endgenerate

endmodule : rob_age_mask
`default_nettype wire

// File: rtl/reorder_buffer_mp.sv
`default_nettype none
// ============================================================================
//  Module   : reorder_buffer_mp
//  Brief    : Circular in-order reorder buffer with N_CDB result buses,
//             N_READ bypassing operand read ports, exception flags and
//             partial flush on branch mispredict.
//  Revision : 2.0 - parametrised multi-CDB successor
// ============================================================================
module reorder_buffer_mp
    import fcpu_pkg::*;
#(
    parameter int DEPTH_W = 3,
    parameter int N_READ  = 6,
    parameter int N_CDB   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    // dispatch
    input  logic                                i_valid,
    output logic                                i_ready,
    output logic [DEPTH_W-1:0]                  i_rsv_id,
    input  logic [REG_ADDR_W-1:0]               i_dst_reg,
    input  logic                                i_no_wait,
    input  logic [INSTR_W-1:0]                  i_opcode,
    // operand read ports
    input  logic [N_READ*DEPTH_W-1:0]           rob_id,
    output logic [N_READ*(DEPTH_W+DATA_W)-1:0]  rob_data,
    output logic [N_READ-1:0]                   rob_data_filled,
    // common data buses
    input  logic [N_CDB-1:0]                    cdb_valid,
    input  logic [N_CDB*DEPTH_W-1:0]            cdb_id,
    input  logic [N_CDB*DATA_W-1:0]             cdb_data,
    input  logic [N_CDB-1:0]                    cdb_exc,
    // mispredict flush
    input  logic                                flush_valid,
    input  logic [DEPTH_W-1:0]                  flush_id,
    // commit
    output logic                                o_valid,
    input  logic                                o_ready,
    output logic [DEPTH_W-1:0]                  o_id,
    output logic [REG_ADDR_W-1:0]               o_dst_reg,
    output logic [INSTR_W-1:0]                  o_opcode,
    output logic [DATA_W-1:0]                   o_content,
    output logic                                o_exc,
    output logic [DEPTH_W:0]                    o_count
);

    localparam int N = 2**DEPTH_W;

    rob_entry_t         entries [N];
    logic [DEPTH_W-1:0] head;
    logic [DEPTH_W-1:0] tail;
    logic [DEPTH_W:0]   count;

    logic               full;
    logic               do_reserve;
    logic               do_commit;
    logic [N-1:0]       younger;
    logic [DEPTH_W:0]   flush_count;

    logic [DEPTH_W-1:0] cdb_id_a   [N_CDB];
    logic [DATA_W-1:0]  cdb_data_a [N_CDB];

    generate
        for (genvar b = 0; b < N_CDB; b++) begin : g_cdb_unpack
            assign cdb_id_a[b]   = cdb_id[b*DEPTH_W +: DEPTH_W];
            assign cdb_data_a[b] = cdb_data[b*DATA_W +: DATA_W];
        end
    endgenerate

    assign full       = (count == (DEPTH_W+1)'(N));
    assign i_ready    = !full && !flush_valid;
    assign i_rsv_id   = tail;
    assign do_reserve = i_valid && i_ready;

    assign o_valid    = entries[head].valid && entries[head].ready;
    assign do_commit  = o_valid && o_ready;
    assign o_id       = head;
    assign o_dst_reg  = entries[head].dst_reg;
    assign o_opcode   = entries[head].opcode;
    assign o_content  = entries[head].content;
    assign o_exc      = entries[head].exc;
    assign o_count    = count;

    // Survivors after a flush are head..flush_id inclusive
    assign flush_count = {1'b0, flush_id - head} + (DEPTH_W+1)'(1);

    rob_age_mask #(
        .DEPTH_W (DEPTH_W)
    ) u_age_mask (
        .head     (head),
        .tail     (tail),
        .flush_id (flush_id),
        .younger  (younger)
    );

    // Head, tail and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_commit)
                head <= head + DEPTH_W'(1);

            if (flush_valid)
                tail <= flush_id + DEPTH_W'(1);
            else if (do_reserve)
                tail <= tail + DEPTH_W'(1);

            if (flush_valid)
                count <= flush_count - {{DEPTH_W{1'b0}}, do_commit};
            else if (do_reserve && !do_commit)
                count <= count + (DEPTH_W+1)'(1);
            else if (!do_reserve && do_commit)
                count <= count - (DEPTH_W+1)'(1);
        end
    end

    // Per-entry update: release and flush override any CDB write landing on
    // the same slot; among buses, the highest index is applied last and wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++)
                entries[k] <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (do_commit && (DEPTH_W'(k) == head)) begin
                    entries[k] <= '0;
                end else if (flush_valid && younger[k]) begin
                    entries[k] <= '0;
                end else if (do_reserve && (DEPTH_W'(k) == tail)) begin
                    entries[k].valid   <= 1'b1;
                    entries[k].ready   <= i_no_wait;
                    entries[k].exc     <= 1'b0;
                    entries[k].dst_reg <= i_dst_reg;
                    entries[k].opcode  <= i_opcode;
                    entries[k].content <= '0;
                end else if (entries[k].valid) begin
                    for (int b = 0; b < N_CDB; b++) begin
                        if (cdb_valid[b] && (cdb_id_a[b] == DEPTH_W'(k))) begin
                            entries[k].ready   <= 1'b1;
                            entries[k].content <= cdb_data_a[b];
                            entries[k].exc     <= cdb_exc[b];
                        end
                    end
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < N_READ; i++) begin : g_read
            logic [DEPTH_W-1:0] rd_id;
            logic [DATA_W-1:0]  rd_content;
            logic               rd_filled;

            assign rd_id = rob_id[i*DEPTH_W +: DEPTH_W];

            // Registered entry state, overridden by a same-cycle CDB hit
            always_comb begin
                rd_content = entries[rd_id].content;
                rd_filled  = entries[rd_id].valid && entries[rd_id].ready;
                for (int b = 0; b < N_CDB; b++) begin
                    if (cdb_valid[b] && (cdb_id_a[b] == rd_id)) begin
                        rd_content = cdb_data_a[b];
                        rd_filled  = 1'b1;
                    end
                end
            end

            assign rob_data[i*(DEPTH_W+DATA_W) +: (DEPTH_W+DATA_W)] = {rd_id, rd_content};
            assign rob_data_filled[i] = rd_filled;
        end
    endgenerate

    // A flush must name a live entry, otherwise the rollback is meaningless
    a_flush_id_valid : assert property (
        @(posedge clk) disable iff (rst) flush_valid |-> entries[flush_id].valid
    );

endmodule : reorder_buffer_mp
`default_nettype wire
